tron_trail_sched: RTL and testbench
===================================

# tron_trail_sched

Controller that sequences the single-port trail BRAM of the Tron game. On `start` it sweeps the BRAM clear. On each game `tick` it reads both players' head cells, decides collisions, and writes the new head marks. It sits between the game-step logic, which supplies positions and ticks, and the trail memory. It owns the `p1_lost`, `p2_lost` and game-over state.

## Interface
Parameters:
- GRID_W, 160, playfield width in cells
- GRID_H, 120, playfield height in cells
- ADDR_W, 15, BRAM address width (GRID_W*GRID_H = 19200 ≤ 2^15)

Ports:
- clk  in  1  system clock (50 MHz)
- resetn  in  1  reset, asynchronous, active-low
- start  in  1  one-cycle pulse: clear board and begin a new game
- tick  in  1  one-cycle pulse: perform one game step
- p1_x  in  8  player 1 head x
- p1_y  in  7  player 1 head y
- p2_x  in  8  player 2 head x
- p2_y  in  7  player 2 head y
- mem_addr  out  ADDR_W  BRAM address
- mem_we  out  1  BRAM write enable
- mem_wdata  out  2  cell value to write
- mem_rdata  in  2  BRAM read data, valid exactly one cycle after `mem_addr`
- ready  out  1  high in PLAY and accepting ticks
- step_done  out  1  one-cycle pulse at end of each step
- p1_lost  out  1  sticky: player 1 collided
- p2_lost  out  1  sticky: player 2 collided
- game_over  out  1  sticky: `p1_lost | p2_lost`

## Operation
- Cell encoding: 00 empty, 01 P1 trail, 10 P2 trail, 11 reserved (treated as occupied).
- Address: `y*GRID_W + x`.
- States:
  - IDLE: on `start` → CLEAR.
  - CLEAR: writes 00 to addresses 0..19199, one per cycle, `mem_we`=1. After the last address → PLAY; both lost flags and `game_over` are cleared on entry.
  - PLAY: `ready`=1. On `tick`, latch all four coordinates → RD1.
  - RD1: issue read at P1 address → RD2.
  - RD2: register P1 hit (`mem_rdata`≠00). Issue read at P2 address → EVAL.
  - EVAL: register P2 hit. Compute the loss terms → WR1.
    - P1 loses on: hit1 | P1 out of bounds | same cell as P2.
    - P2 loses on: hit2 | P2 out of bounds | same cell as P1.
  - WR1: if P1 did not lose, write 01 at P1 address → WR2.
  - WR2: if P2 did not lose, write 10 at P2 address → DONE.
  - DONE: pulse `step_done`; set lost flags. If any flag is set → OVER, else → PLAY.
  - OVER: holds flags, no memory traffic. `start` → CLEAR.
- Out of bounds means x ≥ GRID_W or y ≥ GRID_H. An out-of-bounds player gets no read and no write; its memory cycle drives `mem_we`=0.
- A player trailing onto its own earlier cell loses, because any nonzero cell counts as a hit.
- Head-on (identical coordinates): both lose and neither is written.
- `tick` outside PLAY is ignored and not queued.
- `start` in any state restarts CLEAR from address 0 and clears the flags.
- Coordinates are sampled only on tick acceptance; later changes do not affect the step in progress.

## Timing
- Reset values:
  - State IDLE.
  - `mem_addr`=0, `mem_we`=0, `mem_wdata`=00.
  - `ready`=0, `step_done`=0.
  - `p1_lost`=0, `p2_lost`=0, `game_over`=0.
- Reset is async. Asserting it mid-CLEAR or mid-step drops `mem_we` immediately and aborts any pending write.
- All outputs are registered.
- CLEAR takes 19200 cycles. `ready` rises the cycle after the write to address 19199.
- Step: tick accepted in cycle T.
  - RD1 at T+1, RD2 at T+2, EVAL at T+3, WR1 at T+4, WR2 at T+5.
  - `step_done` pulses at T+6. Lost flags become visible at T+6.
  - `ready` is low from T+1 to T+6 and returns at T+7 if the game continues.
- Minimum tick spacing is 7 cycles.

## Structure
- Shared package `tron_pkg` holds:
  - GRID_W, GRID_H, ADDR_W
  - cell constants CELL_EMPTY, CELL_P1, CELL_P2
  - the scheduler state enum
- One sub-module `tron_cell_addr`: combinational, computes in-bounds and `(y<<7)+(y<<5)+x` from (x,y). Instantiated twice, once per player.
- Clear counter, FSM, hit registers and flags live in the top.

## Test plan
- Reset then `start`: 19200 consecutive writes of 00 at addresses 0..19199. `ready`=1 afterwards. All flags 0.
- Tick with P1=(10,10), P2=(20,20) on an empty board:
  - reads at 1610 then 3220
  - writes 01@1610, 10@3220
  - `step_done` at T+6, no flags set
- Next tick with P1=(11,10), P2=(12,10); a further tick with P2=(11,10): `p2_lost`=1, `game_over`=1, no write at 1611 in that step, FSM in OVER.
- Tick with P1=P2=(50,50): `p1_lost`=`p2_lost`=1, no writes.
- Tick with P1=(160,0): `p1_lost`=1, no P1 access. P2 is still written if free.
- `tick` during CLEAR or OVER is ignored. `start` in OVER reclears the board and clears the flags. Reset asserted mid-step forces `mem_we`=0 immediately and the FSM returns to IDLE.

Source files
------------

// File: rtl/tron_pkg.sv
// Shared constants, cell encoding and scheduler state type for the Tron trail-memory controller.
package tron_pkg;

  localparam int GRID_W = 160;
  localparam int GRID_H = 120;
  localparam int ADDR_W = 15;

  localparam logic [1:0] CELL_EMPTY = 2'b00;
  localparam logic [1:0] CELL_P1    = 2'b01;
  localparam logic [1:0] CELL_P2    = 2'b10;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_PLAY,
    ST_RD1,
    ST_RD2,
    ST_EVAL,
    ST_WR1,
    ST_WR2,
    ST_DONE,
    ST_OVER
  } sched_state_t;

endpackage

// File: rtl/tron_cell_addr.sv
// Maps a head coordinate to a linear trail-memory address and flags whether it lies on the board.
module tron_cell_addr #(
  parameter int GRID_W = tron_pkg::GRID_W,
  parameter int GRID_H = tron_pkg::GRID_H,
  parameter int ADDR_W = tron_pkg::ADDR_W
) (
  input  logic [7:0]        x,
  input  logic [6:0]        y,
  output logic [ADDR_W-1:0] addr,
  output logic              in_bounds
);

  localparam logic [7:0] X_LIM = 8'(GRID_W);
  localparam logic [6:0] Y_LIM = 7'(GRID_H);

  logic [ADDR_W-1:0] x_ext;
  logic [ADDR_W-1:0] y_ext;

  assign x_ext = ADDR_W'(x);
  assign y_ext = ADDR_W'(y);

  // y*160 as two shifts, so no multiplier is needed
  assign addr      = (y_ext << 7) + (y_ext << 5) + x_ext;
  assign in_bounds = (x < X_LIM) && (y < Y_LIM);

endmodule

// File: rtl/tron_trail_sched.sv
// Sequences the single-port trail BRAM: sweeps it clear on start, then per tick reads both heads,
// decides collisions, writes surviving heads and keeps the sticky loss flags.
//
// state | meaning
// IDLE  | after reset, waiting for start
// CLEAR | writing 00 to every cell, one per cycle
// PLAY  | ready, waiting for tick
// RD1   | read P1 head cell
// RD2   | capture P1 hit, read P2 head cell
// EVAL  | capture P2 hit, resolve losses
// WR1   | write P1 mark if P1 survived
// WR2   | write P2 mark if P2 survived
// DONE  | step_done pulse, flags visible
// OVER  | game finished, flags held
module tron_trail_sched #(
  parameter int GRID_W = tron_pkg::GRID_W,
  parameter int GRID_H = tron_pkg::GRID_H,
  parameter int ADDR_W = tron_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic              tick,
  input  logic [7:0]        p1_x,
  input  logic [6:0]        p1_y,
  input  logic [7:0]        p2_x,
  input  logic [6:0]        p2_y,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [1:0]        mem_wdata,
  input  logic [1:0]        mem_rdata,
  output logic              ready,
  output logic              step_done,
  output logic              p1_lost,
  output logic              p2_lost,
  output logic              game_over
);

  import tron_pkg::*;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(GRID_W * GRID_H - 1);

  sched_state_t state, state_nxt;

  logic [7:0] p1_x_q, p2_x_q;
  logic [6:0] p1_y_q, p2_y_q;
  logic [7:0] c1_x, c2_x;
  logic [6:0] c1_y, c2_y;

  logic [ADDR_W-1:0] addr1, addr2;
  logic              inb1, inb2;
  logic              same_cell;

  logic [ADDR_W-1:0] clr_cnt, clr_cnt_nxt;
  logic              hit1_q, hit1_nxt;
  logic              lose1_q, lose1_nxt;
  logic              lose2_q, lose2_nxt;

  logic [ADDR_W-1:0] addr_nxt;
  logic              we_nxt;
  logic [1:0]        wdata_nxt;
  logic              ready_nxt;
  logic              done_nxt;
  logic              p1_lost_nxt, p2_lost_nxt;
  logic              take_tick;

  assign take_tick = (state == ST_PLAY) && tick && !start;

  // In PLAY the live inputs feed the address units so RD1 can issue right after acceptance
  assign c1_x = (state == ST_PLAY) ? p1_x : p1_x_q;
  assign c1_y = (state == ST_PLAY) ? p1_y : p1_y_q;
  assign c2_x = (state == ST_PLAY) ? p2_x : p2_x_q;
  assign c2_y = (state == ST_PLAY) ? p2_y : p2_y_q;

  assign same_cell = (p1_x_q == p2_x_q) && (p1_y_q == p2_y_q);

  tron_cell_addr #(.GRID_W(GRID_W), .GRID_H(GRID_H), .ADDR_W(ADDR_W)) u_addr_p1 (
    .x         (c1_x),
    .y         (c1_y),
    .addr      (addr1),
    .in_bounds (inb1)
  );

  tron_cell_addr #(.GRID_W(GRID_W), .GRID_H(GRID_H), .ADDR_W(ADDR_W)) u_addr_p2 (
    .x         (c2_x),
    .y         (c2_y),
    .addr      (addr2),
    .in_bounds (inb2)
  );

  always_comb begin
    state_nxt   = state;
    addr_nxt    = mem_addr;
    we_nxt      = 1'b0;
    wdata_nxt   = mem_wdata;
    ready_nxt   = 1'b0;
    done_nxt    = 1'b0;
    clr_cnt_nxt = clr_cnt;
    hit1_nxt    = hit1_q;
    lose1_nxt   = lose1_q;
    lose2_nxt   = lose2_q;
    p1_lost_nxt = p1_lost;
    p2_lost_nxt = p2_lost;

    if (start) begin
      state_nxt   = ST_CLEAR;
      addr_nxt    = '0;
      we_nxt      = 1'b1;
      wdata_nxt   = CELL_EMPTY;
      clr_cnt_nxt = LAST_ADDR;
      p1_lost_nxt = 1'b0;
      p2_lost_nxt = 1'b0;
    end else begin
      case (state)
        ST_IDLE: ;
        ST_CLEAR: begin
          if (clr_cnt == '0) begin
            state_nxt   = ST_PLAY;
            ready_nxt   = 1'b1;
            p1_lost_nxt = 1'b0;
            p2_lost_nxt = 1'b0;
          end else begin
            addr_nxt    = mem_addr + 1'b1;
            we_nxt      = 1'b1;
            wdata_nxt   = CELL_EMPTY;
            clr_cnt_nxt = clr_cnt - 1'b1;
          end
        end
        ST_PLAY: begin
          ready_nxt = 1'b1;
          if (take_tick) begin
            state_nxt = ST_RD1;
            ready_nxt = 1'b0;
            if (inb1) addr_nxt = addr1;
          end
        end
        ST_RD1: begin
          state_nxt = ST_RD2;
          if (inb2) addr_nxt = addr2;
        end
        ST_RD2: begin
          state_nxt = ST_EVAL;
          hit1_nxt  = inb1 && (mem_rdata != CELL_EMPTY);
        end
        ST_EVAL: begin
          state_nxt = ST_WR1;
          lose1_nxt = hit1_q || !inb1 || same_cell;
          lose2_nxt = (inb2 && (mem_rdata != CELL_EMPTY)) || !inb2 || same_cell;
          if (!lose1_nxt) begin
            addr_nxt  = addr1;
            we_nxt    = 1'b1;
            wdata_nxt = CELL_P1;
          end
        end
        ST_WR1: begin
          state_nxt = ST_WR2;
          if (!lose2_q) begin
            addr_nxt  = addr2;
            we_nxt    = 1'b1;
            wdata_nxt = CELL_P2;
          end
        end
        ST_WR2: begin
          state_nxt   = ST_DONE;
          done_nxt    = 1'b1;
          p1_lost_nxt = p1_lost | lose1_q;
          p2_lost_nxt = p2_lost | lose2_q;
        end
        ST_DONE: begin
          if (p1_lost || p2_lost) begin
            state_nxt = ST_OVER;
          end else begin
            state_nxt = ST_PLAY;
            ready_nxt = 1'b1;
          end
        end
        ST_OVER: ;
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= ST_IDLE;
      mem_addr  <= '0;
      mem_we    <= 1'b0;
      mem_wdata <= CELL_EMPTY;
      ready     <= 1'b0;
      step_done <= 1'b0;
      p1_lost   <= 1'b0;
      p2_lost   <= 1'b0;
      game_over <= 1'b0;
      clr_cnt   <= '0;
      hit1_q    <= 1'b0;
      lose1_q   <= 1'b0;
      lose2_q   <= 1'b0;
    end else begin
      state     <= state_nxt;
      mem_addr  <= addr_nxt;
      mem_we    <= we_nxt;
      mem_wdata <= wdata_nxt;
      ready     <= ready_nxt;
      step_done <= done_nxt;
      p1_lost   <= p1_lost_nxt;
      p2_lost   <= p2_lost_nxt;
      game_over <= p1_lost_nxt | p2_lost_nxt;
      clr_cnt   <= clr_cnt_nxt;
      hit1_q    <= hit1_nxt;
      lose1_q   <= lose1_nxt;
      lose2_q   <= lose2_nxt;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      p1_x_q <= '0;
      p1_y_q <= '0;
      p2_x_q <= '0;
      p2_y_q <= '0;
    end else if (take_tick) begin
      p1_x_q <= p1_x;
      p1_y_q <= p1_y;
      p2_x_q <= p2_x;
      p2_y_q <= p2_y;
    end
  end

endmodule

// File: tb/tb_tron_trail_sched.sv
// Directed bench for tron_trail_sched: a BRAM model plus a table of game steps with hand-computed results.
module tb_tron_trail_sched;

  localparam int ADDR_W = 15;
  localparam int CELLS  = 19200;

  logic              clk = 1'b0;
  logic              resetn = 1'b0;
  logic              start = 1'b0;
  logic              tick = 1'b0;
  logic [7:0]        p1_x = '0;
  logic [6:0]        p1_y = '0;
  logic [7:0]        p2_x = '0;
  logic [6:0]        p2_y = '0;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [1:0]        mem_wdata;
  logic [1:0]        mem_rdata;
  logic              ready, step_done, p1_lost, p2_lost, game_over;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic        restart;
    logic [7:0]  p1x;
    logic [6:0]  p1y;
    logic [7:0]  p2x;
    logic [6:0]  p2y;
    logic [14:0] a1;
    logic [14:0] a2;
    logic        wr1;
    logic        wr2;
    logic        l1;
    logic        l2;
  } vec_t;

  vec_t vecs [6];

  tron_trail_sched dut (
    .clk       (clk),
    .resetn    (resetn),
    .start     (start),
    .tick      (tick),
    .p1_x      (p1_x),
    .p1_y      (p1_y),
    .p2_x      (p2_x),
    .p2_y      (p2_y),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .ready     (ready),
    .step_done (step_done),
    .p1_lost   (p1_lost),
    .p2_lost   (p2_lost),
    .game_over (game_over)
  );

  always #10 clk = ~clk;

  // Single-port BRAM model, seeded with 11 so a missed clear shows up as an occupied cell
  logic [1:0] bram [0:CELLS-1];
  bit seeded = 1'b0;
  always @(posedge clk) begin
    if (!seeded) begin
      for (int i = 0; i < CELLS; i++) bram[i] <= 2'b11;
      seeded <= 1'b1;
    end else if (int'(mem_addr) < CELLS) begin
      if (mem_we) bram[mem_addr] <= mem_wdata;
      mem_rdata <= bram[mem_addr];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic run_clear(input int idx);
    int bad = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check($sformatf("v%0d_clear_entry", idx), {ready, p1_lost, p2_lost, game_over}, 0);
    for (int k = 0; k < CELLS; k++) begin
      if (k > 0) @(negedge clk);
      if (k == 100) begin
        tick = 1'b1; p1_x = 8'd1; p1_y = 7'd1; p2_x = 8'd2; p2_y = 7'd2;
      end else if (k == 101) begin
        tick = 1'b0;
      end
      if (!(mem_we === 1'b1 && mem_addr === k[14:0] && mem_wdata === 2'b00 && ready === 1'b0))
        bad++;
    end
    check($sformatf("v%0d_clear_bad_cycles", idx), bad, 0);
    @(negedge clk);
    check($sformatf("v%0d_clear_exit", idx), {ready, mem_we, p1_lost, p2_lost, game_over}, 5'b10000);
  endtask

  task automatic wait_ready(input string name);
    int n = 0;
    while (ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check(name, ready, 1);
  endtask

  task automatic run_step(input vec_t v, input int idx);
    logic we_seen;
    wait_ready($sformatf("v%0d_ready", idx));
    p1_x = v.p1x; p1_y = v.p1y; p2_x = v.p2x; p2_y = v.p2y;
    tick = 1'b1;
    @(negedge clk);  // T+1
    tick = 1'b0;
    p1_x = 8'd99; p1_y = 7'd99; p2_x = 8'd98; p2_y = 7'd98;
    check($sformatf("v%0d_rd1_ready_low", idx), ready, 0);
    if (v.p1x < 8'd160 && v.p1y < 7'd120)
      check($sformatf("v%0d_rd1_addr", idx), mem_addr, v.a1);
    we_seen = mem_we;
    @(negedge clk);  // T+2
    check($sformatf("v%0d_rd2_addr", idx), mem_addr, v.a2);
    we_seen = we_seen | mem_we;
    @(negedge clk);  // T+3
    we_seen = we_seen | mem_we;
    check($sformatf("v%0d_read_phase_we", idx), we_seen, 0);
    @(negedge clk);  // T+4
    check($sformatf("v%0d_wr1_we", idx), mem_we, v.wr1);
    if (v.wr1) check($sformatf("v%0d_wr1_cell", idx), {mem_addr, mem_wdata}, {v.a1, 2'b01});
    @(negedge clk);  // T+5
    check($sformatf("v%0d_wr2_we", idx), {mem_we, step_done}, {v.wr2, 1'b0});
    if (v.wr2) check($sformatf("v%0d_wr2_cell", idx), {mem_addr, mem_wdata}, {v.a2, 2'b10});
    @(negedge clk);  // T+6
    check($sformatf("v%0d_step_done", idx), {step_done, mem_we, ready}, 3'b100);
    check($sformatf("v%0d_flags", idx), {p1_lost, p2_lost, game_over}, {v.l1, v.l2, v.l1 | v.l2});
    @(negedge clk);  // T+7
    check($sformatf("v%0d_ready_after", idx), {ready, step_done}, {~(v.l1 | v.l2), 1'b0});
  endtask

  task automatic check_over(input vec_t v, input int idx);
    logic act = 1'b0;
    p1_x = 8'd3; p1_y = 7'd3; p2_x = 8'd4; p2_y = 7'd4;
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    for (int i = 0; i < 8; i++) begin
      act = act | mem_we | step_done | ready;
      @(negedge clk);
    end
    check($sformatf("v%0d_over_quiet", idx), act, 0);
    check($sformatf("v%0d_over_flags", idx), {p1_lost, p2_lost, game_over}, {v.l1, v.l2, 1'b1});
  endtask

  task automatic reset_mid_step();
    logic act = 1'b0;
    wait_ready("rst_ready");
    p1_x = 8'd70; p1_y = 7'd70; p2_x = 8'd80; p2_y = 7'd80;
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    repeat (3) @(negedge clk);  // WR1
    check("rst_pre_write", {mem_we, mem_addr}, {1'b1, 15'd11270});
    #2 resetn = 1'b0;
    #1 check("rst_we_drop", {mem_we, ready, step_done}, 0);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    for (int i = 0; i < 8; i++) begin
      act = act | mem_we | ready | step_done;
      @(negedge clk);
    end
    check("rst_back_idle", act, 0);
  endtask

  initial begin
    #4000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic act = 1'b0;
    vecs[0] = '{1'b1, 8'd10,  7'd10,  8'd20,  7'd20,  15'd1610, 15'd3220,  1'b1, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 8'd11,  7'd10,  8'd12,  7'd10,  15'd1611, 15'd1612,  1'b1, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 8'd11,  7'd11,  8'd11,  7'd10,  15'd1771, 15'd1611,  1'b1, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{1'b1, 8'd50,  7'd50,  8'd50,  7'd50,  15'd8050, 15'd8050,  1'b0, 1'b0, 1'b1, 1'b1};
    vecs[4] = '{1'b1, 8'd0,   7'd0,   8'd159, 7'd119, 15'd0,    15'd19199, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 8'd160, 7'd0,   8'd5,   7'd5,   15'd0,    15'd805,   1'b0, 1'b1, 1'b1, 1'b0};

    repeat (3) @(negedge clk);
    check("reset_outputs",
          {mem_addr, mem_we, mem_wdata, ready, step_done, p1_lost, p2_lost, game_over}, 0);
    resetn = 1'b1;
    @(negedge clk);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    for (int i = 0; i < 5; i++) begin
      act = act | mem_we | ready | step_done;
      @(negedge clk);
    end
    check("idle_ignores_tick", act, 0);

    for (int i = 0; i < 6; i++) begin
      if (i == 5) reset_mid_step();
      if (vecs[i].restart) run_clear(i);
      run_step(vecs[i], i);
      if (vecs[i].l1 || vecs[i].l2) check_over(vecs[i], i);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
